// File: rtl/kmap_pkg.sv
// ---------------------------------------------------------------------------
// kmap_pkg
// Shared definitions for the K-map SOP sweep checker:
//   - kmap_state_e : sweep FSM state encoding (IDLE/SETTLE/SAMPLE/DONE)
//   - VEC_W, N_VEC : minterm vector width and number of minterms
//   - KMAP_EXPECTED_TT : truth table of F = QS + P'R'S + PQR + P'RS + PQ'R'
//                        (bit i = F at minterm i, index {P,Q,R,S})
// ---------------------------------------------------------------------------
package kmap_pkg;

    localparam int VEC_W = 4;
    localparam int N_VEC = 16;

    localparam logic [N_VEC-1:0] KMAP_EXPECTED_TT = 16'hE3AA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } kmap_state_e;

endpackage : kmap_pkg

// File: rtl/kmap_fin_sync.sv
// ---------------------------------------------------------------------------
// kmap_fin_sync
// Multi-flop synchronizer (two stages by default) for the F return path.
// Only instantiated when KMAP_FIN_SYNC_EN is defined.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : raw asynchronous input
//   q   : synchronized output (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module kmap_fin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input into stage 0; the last stage is the output.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : kmap_fin_sync

// File: rtl/kmap_sweep_checker.sv
// ---------------------------------------------------------------------------
// kmap_sweep_checker
// Stimulus and capture stage for the 4-input K-map SOP block. On start it
// drives {p,q,r,s} through minterms 0..15, holds each vector for a settle
// time, samples F, builds the 16-bit truth table and compares it against
// EXPECTED_TT. Results hold until the next accepted start.
//
// Optional build macro: KMAP_FIN_SYNC_EN
//   defined   : f_in passes through a 2-flop synchronizer; SETTLE is
//               stretched by two cycles to cover its latency.
//   undefined : f_in is sampled directly.
//
// Parameters:
//   SETTLE_CYCLES : cycles each vector is held before F is sampled (1..255)
//   EXPECTED_TT   : expected truth table, bit i = F at minterm i
//
// Ports:
//   clk            : system clock, rising edge
//   rst            : asynchronous active-high reset
//   start          : sweep request, honoured only in IDLE
//   f_in           : F returned by the SOP block
//   p, q, r, s     : registered minterm drive ({p,q,r,s} = minterm index)
//   busy           : high from the cycle after start is accepted through DONE
//   done           : one-cycle pulse when the results are valid
//   truth_table    : captured F per minterm
//   pass           : truth_table == EXPECTED_TT, valid from done
//   mismatch_cnt   : number of differing minterms (0..16)
//   first_fail_idx : lowest mismatching minterm (valid when mismatch_cnt != 0)
// ---------------------------------------------------------------------------
module kmap_sweep_checker
    import kmap_pkg::*;
#(
    parameter int unsigned       SETTLE_CYCLES = 2,
    parameter logic [N_VEC-1:0]  EXPECTED_TT   = KMAP_EXPECTED_TT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              f_in,
    output logic              p,
    output logic              q,
    output logic              r,
    output logic              s,
    output logic              busy,
    output logic              done,
    output logic [N_VEC-1:0]  truth_table,
    output logic              pass,
    output logic [4:0]        mismatch_cnt,
    output logic [VEC_W-1:0]  first_fail_idx
);

`ifdef KMAP_FIN_SYNC_EN
    // The synchronizer adds two cycles of latency, so the settle window
    // ends two counts later. One extra counter bit keeps SETTLE_CYCLES=255
    // reachable (terminal count 256).
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES + 1);
`else
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`endif

    // -----------------------------------------------------------------------
    // F sample path
    // -----------------------------------------------------------------------
    logic f_smp;

`ifdef KMAP_FIN_SYNC_EN
    kmap_fin_sync #(
        .STAGES (2)
    ) u_fin_sync (
        .clk (clk),
        .rst (rst),
        .d   (f_in),
        .q   (f_smp)
    );
`else
    assign f_smp = f_in;
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    kmap_state_e       state_q, state_d;
    logic [VEC_W-1:0]  vec_q,   vec_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [N_VEC-1:0]  tt_q,    tt_d;
    logic              pass_q,  pass_d;
    logic [4:0]        mcnt_q,  mcnt_d;
    logic [VEC_W-1:0]  ffi_q,   ffi_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            pass_q  <= 1'b0;
            mcnt_q  <= '0;
            ffi_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
            mcnt_q  <= mcnt_d;
            ffi_q   <= ffi_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        pass_d  = pass_q;
        mcnt_d  = mcnt_q;
        ffi_d   = ffi_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    pass_d  = 1'b0;
                    mcnt_d  = '0;
                    ffi_d   = '0;
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                tt_d[vec_q] = f_smp;
                if (f_smp != EXPECTED_TT[vec_q]) begin
                    mcnt_d = mcnt_q + 1'b1;
                    // Counter still at zero means this is the first mismatch.
                    if (mcnt_q == '0) begin
                        ffi_d = vec_q;
                    end
                end
                if (vec_q == VEC_W'(N_VEC - 1)) begin
                    // Judge on the table including the bit captured now, so
                    // pass is already valid in the DONE cycle.
                    pass_d  = (tt_d == EXPECTED_TT);
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs (all decoded from registers)
    // -----------------------------------------------------------------------
    assign {p, q, r, s}    = vec_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign truth_table     = tt_q;
    assign pass            = pass_q;
    assign mismatch_cnt    = mcnt_q;
    assign first_fail_idx  = ffi_q;

endmodule : kmap_sweep_checker

// File: tb/tb_kmap_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_kmap_sweep_checker
// Directed bench for kmap_sweep_checker: loopback through a model of the SOP
// function, tied-0 / tied-1 F, start re-pulse and held start, and a mid-sweep
// reset. One line per transaction plus a final summary line.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_kmap_sweep_checker;

`ifdef KMAP_FIN_SYNC_EN
    localparam int DONE_EDGE = 80;
`else
    localparam int DONE_EDGE = 48;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        f_in;
    logic        p_o, q_o, r_o, s_o;
    logic        busy, done, pass;
    logic [15:0] tt;
    logic [4:0]  mcnt;
    logic [3:0]  ffi;

    // 0 = loopback through SOP model, 1 = tied 0, 2 = tied 1
    logic [1:0]  fin_mode;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // F = QS + P'R'S + PQR + P'RS + PQ'R'
    always_comb begin
        f_in = 1'b0;
        case (fin_mode)
            2'd0:    f_in = (q_o & s_o) | (~p_o & ~r_o & s_o) | (p_o & q_o & r_o)
                          | (~p_o & r_o & s_o) | (p_o & ~q_o & ~r_o);
            2'd1:    f_in = 1'b0;
            default: f_in = 1'b1;
        endcase
    end

    kmap_sweep_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .f_in           (f_in),
        .p              (p_o),
        .q              (q_o),
        .r              (r_o),
        .s              (s_o),
        .busy           (busy),
        .done           (done),
        .truth_table    (tt),
        .pass           (pass),
        .mismatch_cnt   (mcnt),
        .first_fail_idx (ffi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a sweep at the next edge (edge 0) and observes max_edges more
    // edges, #1 after each. Records first done edge, done count, busy trace.
    task automatic sweep(input bit hold, input int repulse, input int max_edges,
                         output int first_done, output int ndone,
                         output logic [255:0] btrace);
        first_done = -1;
        ndone      = 0;
        btrace     = '0;
        start = 1'b1;
        @(posedge clk); #1;
        check("clr_pass", {31'd0, pass}, 32'd0);
        check("clr_mcnt", {27'd0, mcnt}, 32'd0);
        for (int e = 1; e <= max_edges; e++) begin
            if (!hold) start = (e == repulse);
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = e;
            end
            btrace[e] = busy;
        end
    endtask

    int              fd, nd, lows;
    bit              found;
    logic [255:0]    bt;

    initial begin
        rst = 1'b1; start = 1'b0; fin_mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pqrs", {28'd0, p_o, q_o, r_o, s_o}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_tt", {16'd0, tt}, 32'd0);
        check("rst_pass_cnt_idx", {22'd0, pass, mcnt, ffi}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        $display("txn reset: busy=%0b tt=%04h", busy, tt);

        // Loopback sweep
        fin_mode = 2'd0;
        sweep(1'b0, -1, DONE_EDGE + 10, fd, nd, bt);
        check("loop_done_edge", fd, DONE_EDGE);
        check("loop_done_cnt", nd, 1);
        check("loop_tt", {16'd0, tt}, 32'h0000_E3AA);
        check("loop_pass", {31'd0, pass}, 32'd1);
        check("loop_mcnt", {27'd0, mcnt}, 32'd0);
        check("loop_vec_end", {28'd0, p_o, q_o, r_o, s_o}, 32'hF);
        check("loop_busy_end", {31'd0, busy}, 32'd0);
        $display("txn loopback: done_edge=%0d tt=%04h pass=%0b mcnt=%0d", fd, tt, pass, mcnt);

        // F tied 0
        fin_mode = 2'd1;
        sweep(1'b0, -1, DONE_EDGE + 5, fd, nd, bt);
        check("t0_done_edge", fd, DONE_EDGE);
        check("t0_tt", {16'd0, tt}, 32'h0000_0000);
        check("t0_pass", {31'd0, pass}, 32'd0);
        check("t0_mcnt", {27'd0, mcnt}, 32'd9);
        check("t0_ffi", {28'd0, ffi}, 32'd1);
        $display("txn tied0: tt=%04h pass=%0b mcnt=%0d ffi=%0d", tt, pass, mcnt, ffi);

        // F tied 1
        fin_mode = 2'd2;
        sweep(1'b0, -1, DONE_EDGE + 5, fd, nd, bt);
        check("t1_tt", {16'd0, tt}, 32'h0000_FFFF);
        check("t1_pass", {31'd0, pass}, 32'd0);
        check("t1_mcnt", {27'd0, mcnt}, 32'd7);
        check("t1_ffi", {28'd0, ffi}, 32'd0);
        // Results hold while idle
        repeat (7) @(posedge clk);
        #1;
        check("t1_hold_mcnt", {27'd0, mcnt}, 32'd7);
        $display("txn tied1: tt=%04h pass=%0b mcnt=%0d ffi=%0d", tt, pass, mcnt, ffi);

        // Start re-pulsed at edge 10 mid-sweep: ignored
        fin_mode = 2'd0;
        sweep(1'b0, 10, DONE_EDGE + 20, fd, nd, bt);
        check("rep_done_edge", fd, DONE_EDGE);
        check("rep_done_cnt", nd, 1);
        check("rep_pass", {31'd0, pass}, 32'd1);
        $display("txn repulse: done_edge=%0d ndone=%0d pass=%0b", fd, nd, pass);

        // Start held high: re-accepted in the IDLE cycle after DONE
        sweep(1'b1, -1, DONE_EDGE + 2, fd, nd, bt);
        lows = 0;
        for (int e = 1; e <= DONE_EDGE; e++) if (bt[e] !== 1'b1) lows++;
        check("hold_done_edge", fd, DONE_EDGE);
        check("hold_done_cnt", nd, 1);
        check("hold_busy_gaps", lows, 0);
        check("hold_busy_idle", {31'd0, bt[DONE_EDGE + 1]}, 32'd0);
        check("hold_busy_rearm", {31'd0, bt[DONE_EDGE + 2]}, 32'd1);
        start = 1'b0;
        found = 1'b0;
        for (int e = 1; e <= DONE_EDGE + 20; e++) begin
            @(posedge clk); #1;
            if (!found && done === 1'b1) begin
                found = 1'b1;
                fd = e;
            end
        end
        check("hold_2nd_done", {31'd0, found}, 32'd1);
        check("hold_2nd_edge", fd, DONE_EDGE);
        check("hold_2nd_tt", {16'd0, tt}, 32'h0000_E3AA);
        $display("txn hold: 2nd done after %0d edges tt=%04h", fd, tt);

        // Reset asserted at edge 20 of a sweep
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
`ifndef KMAP_FIN_SYNC_EN
        check("mid_tt", {16'd0, tt}, 32'h0000_002A);
        check("mid_vec", {28'd0, p_o, q_o, r_o, s_o}, 32'd6);
`endif
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_pqrs", {28'd0, p_o, q_o, r_o, s_o}, 32'd0);
        check("arst_busy_done", {30'd0, busy, done}, 32'd0);
        check("arst_tt", {16'd0, tt}, 32'd0);
        check("arst_pass_cnt_idx", {22'd0, pass, mcnt, ffi}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nd = 0; lows = 0;
        for (int e = 0; e < 100; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
            if (busy !== 1'b0) lows++;
        end
        check("arst_no_done", nd, 0);
        check("arst_stay_idle", lows, 0);
        $display("txn midreset: dones=%0d busy_cycles=%0d", nd, lows);

        // Recovery sweep
        sweep(1'b0, -1, DONE_EDGE + 5, fd, nd, bt);
        check("rec_done_edge", fd, DONE_EDGE);
        check("rec_pass", {31'd0, pass}, 32'd1);
        $display("txn recovery: done_edge=%0d tt=%04h pass=%0b", fd, tt, pass);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_kmap_sweep_checker
